// File: rtl/timer_array.sv
// Multi-channel down-counter/timer with per-channel prescaler, one-shot,
// periodic and PWM modes, sticky FLAG and a maskable combined interrupt.
module timer_array #(
    parameter int NCH    = 4,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = $clog2(NCH) + 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [NCH-1:0]    ch_out,
    output logic              irq
);
    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_PWM      = 2'b10,
        MODE_HALT     = 2'b11
    } mode_t;

    logic [7:0]     ch_idx;
    logic [31:0]    ch_rdata [NCH];
    logic [NCH-1:0] irq_vec;

    // A single-channel build has no channel-select bits at all.
    if (ADDR_W > 4) begin : g_idx
        assign ch_idx = 8'(addr[ADDR_W-1:4]);
    end else begin : g_idx0
        assign ch_idx = 8'd0;
    end

    genvar gi;
    for (gi = 0; gi < NCH; gi++) begin : g_ch
        logic             en_reg, en_next;
        mode_t            mode_reg, mode_next;
        logic             irq_en_reg, irq_en_next;
        logic [7:0]       pre_reg, pre_next;
        logic [7:0]       presc_reg, presc_next;
        logic             flag_reg, flag_next;
        logic [WIDTH-1:0] load_reg, load_next;
        logic [WIDTH-1:0] cmp_reg, cmp_next;
        logic [WIDTH-1:0] count_reg, count_next;
        logic             ch_out_reg, ch_out_next;
        logic             sel, active, tick, expire;
        logic [31:0]      ctrl_word, load_word, cmp_word, count_word;

        assign sel    = we && (ch_idx == 8'(gi));
        assign active = en_reg && (mode_reg != MODE_HALT);
        assign tick   = active && (presc_reg == pre_reg);
        assign expire = tick && (count_reg == '0);

        always_comb begin
            en_next     = en_reg;
            mode_next   = mode_reg;
            irq_en_next = irq_en_reg;
            pre_next    = pre_reg;
            flag_next   = flag_reg;
            load_next   = load_reg;
            cmp_next    = cmp_reg;
            count_next  = count_reg;
            presc_next  = (active && !tick) ? presc_reg + 8'd1 : 8'd0;

            if (tick) begin
                if (!expire)
                    count_next = count_reg - WIDTH'(1);
                else if (mode_reg == MODE_ONESHOT)
                    en_next = 1'b0;
                else
                    count_next = load_reg;
            end

            // Bus writes override the tick's effect on the same fields.
            if (sel) begin
                case (addr[3:2])
                    2'd0: begin
                        en_next     = wdata[0];
                        mode_next   = mode_t'(wdata[2:1]);
                        irq_en_next = wdata[3];
                        pre_next    = wdata[15:8];
                        if (wdata[0] && !en_reg)
                            presc_next = 8'd0;
                        if (wdata[31])
                            flag_next = 1'b0;
                    end
                    2'd1: begin
                        load_next  = wdata[WIDTH-1:0];
                        count_next = wdata[WIDTH-1:0];
                        presc_next = 8'd0;
                    end
                    2'd2:    cmp_next = wdata[WIDTH-1:0];
                    default: ;
                endcase
            end

            // A simultaneous clear never hides an expiry.
            if (expire)
                flag_next = 1'b1;

            ch_out_next = ch_out_reg;
            case (mode_next)
                MODE_ONESHOT:  ch_out_next = en_next;
                MODE_PERIODIC: if (expire && mode_reg == MODE_PERIODIC) ch_out_next = !ch_out_reg;
                MODE_PWM:      if (en_next) ch_out_next = (count_next < cmp_next);
                default:       ;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                en_reg     <= 1'b0;
                mode_reg   <= MODE_ONESHOT;
                irq_en_reg <= 1'b0;
                pre_reg    <= 8'd0;
                presc_reg  <= 8'd0;
                flag_reg   <= 1'b0;
                load_reg   <= '0;
                cmp_reg    <= '0;
                count_reg  <= '0;
                ch_out_reg <= 1'b0;
            end else begin
                en_reg     <= en_next;
                mode_reg   <= mode_next;
                irq_en_reg <= irq_en_next;
                pre_reg    <= pre_next;
                presc_reg  <= presc_next;
                flag_reg   <= flag_next;
                load_reg   <= load_next;
                cmp_reg    <= cmp_next;
                count_reg  <= count_next;
                ch_out_reg <= ch_out_next;
            end
        end

        always_comb begin
            ctrl_word        = '0;
            ctrl_word[0]     = en_reg;
            ctrl_word[2:1]   = mode_reg;
            ctrl_word[3]     = irq_en_reg;
            ctrl_word[15:8]  = pre_reg;
            ctrl_word[31]    = flag_reg;
            load_word        = '0;
            load_word[WIDTH-1:0]  = load_reg;
            cmp_word         = '0;
            cmp_word[WIDTH-1:0]   = cmp_reg;
            count_word       = '0;
            count_word[WIDTH-1:0] = count_reg;
        end

        always_comb begin
            case (addr[3:2])
                2'd0:    ch_rdata[gi] = ctrl_word;
                2'd1:    ch_rdata[gi] = load_word;
                2'd2:    ch_rdata[gi] = cmp_word;
                default: ch_rdata[gi] = count_word;
            endcase
        end

        assign irq_vec[gi] = flag_reg && irq_en_reg;
        assign ch_out[gi]  = ch_out_reg;
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NCH; i++)
            if (ch_idx == 8'(i))
                rdata = ch_rdata[i];
    end

    assign irq = |irq_vec;

endmodule

// File: tb/tb_timer_array.sv
// Directed bench for timer_array (NCH=3, WIDTH=8) with hand-computed expectations.
module tb_timer_array;
    localparam int NCH = 3;
    localparam int WIDTH = 8;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic [NCH-1:0]    ch_out;
    logic              irq;

    int vectors = 0;
    int miscompares = 0;

    timer_array #(.NCH(NCH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .ch_out (ch_out),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    // Writes occupy one full cycle, returning at the following negedge.
    task automatic wr(input int ch, input int r, input logic [31:0] d);
        addr  = ADDR_W'(ch * 16 + r * 4);
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic rd(input int ch, input int r, output logic [31:0] d);
        addr = ADDR_W'(ch * 16 + r * 4);
        #1 d = rdata;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        for (int c = 0; c < NCH; c++) begin
            for (int r = 0; r < 4; r++) begin
                rd(c, r, v);
                vectors++;
                if (v !== 32'h0) begin
                    $display("FAIL reset_reg ch%0d r%0d got %h want 0", c, r, v);
                    miscompares++;
                end
            end
        end
        vectors++;
        if (ch_out !== 3'b000 || irq !== 1'b0) begin
            $display("FAIL reset_out got ch_out=%b irq=%b want 000/0", ch_out, irq);
            miscompares++;
        end
        $display("reset: registers and outputs checked");
    endtask

    task automatic test_oneshot;
        logic [31:0] v;
        wr(0, 1, 32'd3);
        @(negedge clk);
        wr(0, 0, 32'h9);
        rd(0, 3, v);
        vectors++;
        if (v !== 32'd3 || ch_out[0] !== 1'b1) begin
            $display("FAIL oneshot_start got count=%0d ch_out=%b want 3/1", v, ch_out[0]);
            miscompares++;
        end
        repeat (3) @(negedge clk);
        rd(0, 0, v);
        vectors++;
        if (v !== 32'h9 || irq !== 1'b0 || ch_out[0] !== 1'b1) begin
            $display("FAIL oneshot_pre got ctrl=%h irq=%b ch_out=%b want 00000009/0/1", v, irq, ch_out[0]);
            miscompares++;
        end
        @(negedge clk);
        rd(0, 0, v);
        vectors++;
        if (v !== 32'h8000_0008 || irq !== 1'b1 || ch_out[0] !== 1'b0) begin
            $display("FAIL oneshot_expire got ctrl=%h irq=%b ch_out=%b want 80000008/1/0", v, irq, ch_out[0]);
            miscompares++;
        end
        rd(0, 3, v);
        vectors++;
        if (v !== 32'd0) begin
            $display("FAIL oneshot_count got %0d want 0", v);
            miscompares++;
        end
        wr(0, 0, 32'h8000_0008);
        rd(0, 0, v);
        vectors++;
        if (v !== 32'h8 || irq !== 1'b0) begin
            $display("FAIL oneshot_w1c got ctrl=%h irq=%b want 00000008/0", v, irq);
            miscompares++;
        end
        wr(0, 0, 32'h0);
        $display("oneshot: ch0 LOAD=3 PRE=0 checked");
    endtask

    task automatic test_periodic;
        logic [31:0] v;
        logic [31:0] exp_cnt [6] = '{32'd2, 32'd2, 32'd1, 32'd1, 32'd0, 32'd0};
        wr(1, 1, 32'd2);
        wr(1, 0, 32'h103);
        for (int k = 0; k < 6; k++) begin
            rd(1, 3, v);
            vectors++;
            if (v !== exp_cnt[k] || ch_out[1] !== 1'b0) begin
                $display("FAIL periodic_seq k=%0d got count=%0d ch_out=%b want %0d/0", k, v, ch_out[1], exp_cnt[k]);
                miscompares++;
            end
            @(negedge clk);
        end
        rd(1, 0, v);
        vectors++;
        if (v !== 32'h8000_0103 || ch_out[1] !== 1'b1 || irq !== 1'b0) begin
            $display("FAIL periodic_reload got ctrl=%h ch_out=%b irq=%b want 80000103/1/0", v, ch_out[1], irq);
            miscompares++;
        end
        rd(1, 3, v);
        vectors++;
        if (v !== 32'd2) begin
            $display("FAIL periodic_reload_count got %0d want 2", v);
            miscompares++;
        end
        wr(1, 0, 32'h102);
        repeat (4) @(negedge clk);
        rd(1, 3, v);
        vectors++;
        if (v !== 32'd2 || ch_out[1] !== 1'b1) begin
            $display("FAIL periodic_freeze got count=%0d ch_out=%b want 2/1", v, ch_out[1]);
            miscompares++;
        end
        wr(1, 0, 32'h103);
        repeat (5) @(negedge clk);
        rd(1, 3, v);
        vectors++;
        if (v !== 32'd0 || ch_out[1] !== 1'b1) begin
            $display("FAIL periodic_resume got count=%0d ch_out=%b want 0/1", v, ch_out[1]);
            miscompares++;
        end
        @(negedge clk);
        rd(1, 3, v);
        vectors++;
        if (v !== 32'd2 || ch_out[1] !== 1'b0) begin
            $display("FAIL periodic_toggle got count=%0d ch_out=%b want 2/0", v, ch_out[1]);
            miscompares++;
        end
        wr(1, 0, 32'h8000_0000);
        $display("periodic: ch1 LOAD=2 PRE=1 checked");
    endtask

    task automatic test_pwm;
        int high;
        logic [31:0] v;
        int cmp_tab [3] = '{3, 0, 12};
        int exp_high [3] = '{6, 0, 20};
        wr(2, 1, 32'd9);
        for (int t = 0; t < 3; t++) begin
            wr(2, 2, 32'(cmp_tab[t]));
            if (t == 0) begin
                wr(2, 0, 32'h5);
                rd(2, 3, v);
                vectors++;
                if (v !== 32'd9 || ch_out[2] !== 1'b0) begin
                    $display("FAIL pwm_start got count=%0d ch_out=%b want 9/0", v, ch_out[2]);
                    miscompares++;
                end
            end
            high = 0;
            for (int k = 0; k < 20; k++) begin
                if (ch_out[2] === 1'b1) high++;
                @(negedge clk);
            end
            vectors++;
            if (high !== exp_high[t]) begin
                $display("FAIL pwm_duty cmp=%0d got high=%0d want %0d", cmp_tab[t], high, exp_high[t]);
                miscompares++;
            end
            $display("pwm: cmp=%0d high %0d of 20", cmp_tab[t], high);
        end
    endtask

    task automatic test_collision;
        logic [31:0] v;
        logic a;
        // ch2 still runs PWM with PRE=0, so every cycle is a tick.
        wr(2, 1, 32'd5);
        rd(2, 3, v);
        vectors++;
        if (v !== 32'd5) begin
            $display("FAIL collide_load got count=%0d want 5", v);
            miscompares++;
        end
        @(negedge clk);
        rd(2, 3, v);
        vectors++;
        if (v !== 32'd4) begin
            $display("FAIL collide_next got count=%0d want 4", v);
            miscompares++;
        end
        wr(2, 0, 32'h0);
        wr(2, 0, 32'h8000_0000);
        wr(2, 1, 32'd0);
        wr(1, 1, 32'd0);
        wr(1, 0, 32'h3);
        wr(1, 0, 32'h8000_0003);
        rd(1, 0, v);
        vectors++;
        if (v !== 32'h8000_0003) begin
            $display("FAIL collide_flag got ctrl=%h want 80000003", v);
            miscompares++;
        end
        a = ch_out[1];
        @(negedge clk);
        vectors++;
        if (ch_out[1] !== !a) begin
            $display("FAIL load0_toggle got ch_out=%b want %b", ch_out[1], !a);
            miscompares++;
        end
        wr(1, 0, 32'h0);
        wr(1, 0, 32'h8000_0000);
        rd(1, 0, v);
        vectors++;
        if (v !== 32'h0) begin
            $display("FAIL collide_cleanup got ctrl=%h want 0", v);
            miscompares++;
        end
        $display("collision: load and flag collisions checked");
    endtask

    task automatic test_range;
        logic [31:0] v;
        wr(0, 1, 32'h1FF);
        rd(0, 1, v);
        vectors++;
        if (v !== 32'hFF) begin
            $display("FAIL range_trunc got %h want 000000ff", v);
            miscompares++;
        end
        wr(3, 1, 32'd5);
        rd(3, 1, v);
        vectors++;
        if (v !== 32'h0) begin
            $display("FAIL range_ch3 got %h want 0", v);
            miscompares++;
        end
        rd(0, 3, v);
        vectors++;
        if (v !== 32'hFF) begin
            $display("FAIL range_count got %h want 000000ff", v);
            miscompares++;
        end
        $display("range: truncation and out-of-range channel checked");
    endtask

    task automatic test_independence;
        logic [31:0] v;
        wr(0, 1, 32'd5);
        wr(0, 0, 32'h1);
        wr(1, 1, 32'd1);
        wr(1, 0, 32'h3);
        rd(0, 3, v);
        vectors++;
        if (v !== 32'd3) begin
            $display("FAIL indep_ch0 got count=%0d want 3", v);
            miscompares++;
        end
        rd(1, 3, v);
        vectors++;
        if (v !== 32'd1) begin
            $display("FAIL indep_ch1 got count=%0d want 1", v);
            miscompares++;
        end
        rd(2, 3, v);
        vectors++;
        if (v !== 32'd0 || ch_out[2] !== 1'b0) begin
            $display("FAIL indep_ch2 got count=%0d ch_out=%b want 0/0", v, ch_out[2]);
            miscompares++;
        end
        repeat (4) @(negedge clk);
        rd(0, 0, v);
        vectors++;
        if (v !== 32'h8000_0000 || irq !== 1'b0 || ch_out[0] !== 1'b0) begin
            $display("FAIL indep_mask got ctrl=%h irq=%b ch_out=%b want 80000000/0/0", v, irq, ch_out[0]);
            miscompares++;
        end
        wr(0, 0, 32'h8);
        vectors++;
        if (irq !== 1'b1) begin
            $display("FAIL indep_unmask got irq=%b want 1", irq);
            miscompares++;
        end
        wr(1, 0, 32'h0);
        wr(1, 0, 32'h8000_0000);
        wr(0, 0, 32'h8000_0000);
        $display("independence: three channels and irq mask checked");
    endtask

    task automatic test_reset_midcount;
        wr(0, 1, 32'd100);
        wr(0, 0, 32'h9);
        wr(2, 1, 32'd9);
        wr(2, 2, 32'd3);
        wr(2, 0, 32'h5);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (ch_out !== 3'b000 || irq !== 1'b0) begin
            $display("FAIL reset_async got ch_out=%b irq=%b want 000/0", ch_out, irq);
            miscompares++;
        end
        @(negedge clk);
        rst = 1'b0;
        test_reset;
        $display("reset: mid-count abort checked");
    endtask

    initial begin
        rst   = 1'b1;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset;
        test_oneshot;
        test_periodic;
        test_pwm;
        test_collision;
        test_range;
        test_independence;
        test_reset_midcount;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/timer_array.md
# timer_array

Parametrised multi-channel down-counter/timer peripheral. It succeeds the fixed three-channel counter on the MIO bus: N independent channels, configurable width, a per-channel prescaler, one-shot, periodic and PWM modes, sticky status and a maskable combined interrupt. It sits behind the bus decoder's counter select, shares the CPU clock domain, and drives the CPU `INT` line.

## Interface
Parameters:
- `NCH`, 4: number of channels (1–16).
- `WIDTH`, 32: counter, LOAD and CMP width (1–32); reads zero-extend, writes truncate.
- `ADDR_W`, `$clog2(NCH)+4`: byte-address width; `addr[ADDR_W-1:4]` selects the channel, `addr[3:2]` the register, `addr[1:0]` is ignored.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `we` in 1: write strobe, one write per cycle.
- `addr` in ADDR_W: register byte address.
- `wdata` in 32: write data.
- `rdata` out 32: combinational read of the addressed register; 0 for channel ≥ NCH.
- `ch_out` out NCH: per-channel waveform output, registered.
- `irq` out 1: OR over channels of (FLAG & IRQ_EN).

## Operation
- Per-channel registers, by `addr[3:2]`:
  - 0 CTRL: [0] EN, [2:1] MODE (00 one-shot, 01 periodic, 10 PWM, 11 reserved, treated as halted), [3] IRQ_EN, [15:8] PRE, [31] FLAG. Writing 1 to bit 31 clears FLAG; writing 0 has no effect. All other bits read as 0.
  - 1 LOAD: reload value. A write also copies the value into COUNT and clears the prescaler.
  - 2 CMP: PWM compare value.
  - 3 COUNT: read-only; writes are ignored.
- Prescaler:
  - Counts 0..PRE while EN=1 and MODE≠11.
  - A tick is produced in the cycle the prescaler equals PRE; the prescaler then returns to 0.
  - Tick period is PRE+1 clocks. PRE=0 gives a tick every clock.
  - The prescaler is held at 0 while disabled.
  - A CTRL write that takes EN from 0 to 1 clears the prescaler.
- On a tick:
  - COUNT≠0: COUNT decrements by 1.
  - COUNT=0, one-shot: FLAG set, EN cleared, COUNT stays 0.
  - COUNT=0, periodic or PWM: FLAG set, COUNT reloaded from LOAD. Periodic also toggles `ch_out`.
- `ch_out`:
  - One-shot: 1 while EN=1, 0 otherwise.
  - Periodic: toggles at each reload.
  - PWM: registered `(COUNT < CMP)`. CMP=0 gives constant 0; CMP>LOAD gives constant 1.
- Boundary rules:
  - LOAD=0 in periodic mode sets FLAG on every tick.
  - A bus write and a tick in the same cycle to the same channel: the written LOAD/COUNT wins, and that tick's decrement is dropped.
  - A FLAG clear and a FLAG set in the same cycle: the set wins, so no event is lost.
  - Disabling (EN←0) freezes COUNT and `ch_out`. Re-enabling resumes from the frozen COUNT.
  - Channels are fully independent.

## Timing
- Reset (asynchronous): all CTRL, LOAD, CMP, COUNT, prescaler and FLAG go to 0; `ch_out`=0; `irq`=0.
- Register writes take effect at the clock edge.
- Read-after-write shows the new value in the next cycle.
- `rdata` is combinational from the registers with no wait states.
- FLAG and COUNT update at the edge that ends the tick cycle. `irq` follows FLAG combinationally, so it is visible in the same cycle FLAG reads 1.
- One-shot with EN written 1 at edge T, LOAD=L, PRE=P:
  - FLAG is set at edge T+(L+1)(P+1).
  - `ch_out` falls at the same edge.
- Periodic: `ch_out` period is 2(L+1)(P+1) clocks.
- PWM: period is (L+1)(P+1) clocks; high time is CMP·(P+1) clocks.
- `rst` asserted mid-count aborts immediately. No state survives.

## Test plan
- Reset: assert `rst` mid-count with EN=1 → all registers read 0, `ch_out`=0, `irq`=0 on the next read.
- One-shot, ch0: LOAD=3, PRE=0, CTRL=0x9 → FLAG and `irq` rise 4 clocks after enable; EN reads 0; COUNT=0; `ch_out` 1→0. W1C on bit 31 drops `irq` the next cycle.
- Periodic with prescaler, ch1: LOAD=2, PRE=1, MODE=01 → `ch_out` toggles every 6 clocks; FLAG set each period; COUNT sequence 2,1,0,2…
- PWM, ch2: LOAD=9, CMP=3, PRE=0 → `ch_out` high 3 of every 10 clocks. CMP=0 gives constant 0; CMP=12 gives constant 1.
- Collisions: LOAD write in a tick cycle → COUNT equals the written value with no decrement. FLAG clear in the same cycle as a FLAG set → FLAG reads 1.
- Independence and range: NCH=3, WIDTH=8. LOAD=0x1FF → reads 0xFF. Channels 0–2 running concurrently → no cross-effects; `irq` masked when IRQ_EN=0; reads of channel 3 return 0.
